// File: rtl/rv32i_pkg.sv
// Shared rv32i datapath widths and the EX->MEM payload types.
// The skid-buffer state encoding lives here so any pipeline register can reuse it.
package rv32i_pkg;

  localparam int DPW = 32;
  localparam int RAW = 5;

  typedef struct packed {
    logic regwrite;
    logic resultsrc;
    logic memwrite;
  } ex_mem_ctrl_t;

  typedef struct packed {
    ex_mem_ctrl_t   ctrl;
    logic [DPW-1:0] aluresult;
    logic [DPW-1:0] Rd2;
    logic [RAW-1:0] Rd;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    SKB_EMPTY = 2'd0,
    SKB_ONE   = 2'd1,
    SKB_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage register on any payload type; 1-cycle latency when empty.
// SKID=1: 2-entry skid, in_ready from flops only; SKID=0: one entry, in_ready = !out_valid || out_ready.
module pipe_skid_buf
  import rv32i_pkg::*;
#(
  parameter type T    = logic [7:0],
  parameter bit  SKID = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  generate
    if (SKID) begin : g_skid
      skid_state_t state_q, state_d;
      T            main_q, main_d;
      T            skid_q, skid_d;
      logic        accept, handover;

      assign in_ready  = (state_q != SKB_FULL);
      assign out_valid = (state_q != SKB_EMPTY);
      assign out_data  = main_q;
      assign accept    = in_valid && in_ready;
      assign handover  = out_valid && out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= SKB_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      // Flush is checked first so a discarded payload never disturbs the held outputs.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = SKB_EMPTY;
        end else begin
          case (state_q)
            SKB_EMPTY: begin
              if (accept) begin
                state_d = SKB_ONE;
                main_d  = in_data;
              end
            end
            SKB_ONE: begin
              if (accept && handover) begin
                main_d = in_data;
              end else if (accept) begin
                state_d = SKB_FULL;
                skid_d  = in_data;
              end else if (handover) begin
                state_d = SKB_EMPTY;
              end
            end
            SKB_FULL: begin
              if (handover) begin
                state_d = SKB_ONE;
                main_d  = skid_q;
              end
            end
            default: state_d = SKB_EMPTY;
          endcase
        end
      end
    end else begin : g_flat
      logic valid_q;
      T     main_q;

      assign in_ready  = !valid_q || out_ready;
      assign out_valid = valid_q;
      assign out_data  = main_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
          valid_q <= 1'b1;
          main_q  <= in_data;
        end else if (out_ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM valid/ready boundary with flush, bubble squashing and a saturating stall counter; 1-cycle latency.
// Backpressure via readyE: registered with SKID=1 (2-entry skid), combinational with SKID=0.
module ex_mem_skid_reg
  import rv32i_pkg::*;
#(
  parameter bit SKID = 1'b1,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            validE,
  output logic            readyE,
  input  logic            regwriteE,
  input  logic            resultsrcE,
  input  logic            memwriteE,
  input  logic [DPW-1:0]  aluresultE,
  input  logic [DPW-1:0]  Rd2E,
  input  logic [RAW-1:0]  RdE,
  output logic            validM,
  input  logic            readyM,
  output logic            regwriteM,
  output logic            resultsrcM,
  output logic            memwriteM,
  output logic [DPW-1:0]  aluresultM,
  output logic [DPW-1:0]  Rd2M,
  output logic [RAW-1:0]  RdM,
  output logic [CNTW-1:0] stall_cnt
);

  ex_mem_payload_t in_pay;
  ex_mem_payload_t out_pay;

  assign in_pay = '{ctrl: '{regwrite: regwriteE, resultsrc: resultsrcE, memwrite: memwriteE},
                    aluresult: aluresultE, Rd2: Rd2E, Rd: RdE};

  pipe_skid_buf #(
    .T    (ex_mem_payload_t),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (validE),
    .in_ready  (readyE),
    .in_data   (in_pay),
    .out_valid (validM),
    .out_ready (readyM),
    .out_data  (out_pay)
  );

  // Side-effecting controls must never leak out of a bubble.
  assign regwriteM  = validM && out_pay.ctrl.regwrite;
  assign memwriteM  = validM && out_pay.ctrl.memwrite;
  assign resultsrcM = out_pay.ctrl.resultsrc;
  assign aluresultM = out_pay.aluresult;
  assign Rd2M       = out_pay.Rd2;
  assign RdM        = out_pay.Rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (validM && !readyM && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed and scoreboarded checks of ex_mem_skid_reg with SKID=1 and SKID=0 instances.
`timescale 1ns/1ps
module tb_ex_mem_skid_reg;
  import rv32i_pkg::*;

  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n, flush_i, validE, readyM, regwriteE, resultsrcE, memwriteE;
  logic [DPW-1:0] aluresultE, Rd2E;
  logic [RAW-1:0] RdE;
  logic use_skid;

  logic s_validE, s_readyE, s_validM, s_regwriteM, s_resultsrcM, s_memwriteM;
  logic [DPW-1:0] s_aluresultM, s_Rd2M;
  logic [RAW-1:0] s_RdM;
  logic [CNTW-1:0] s_stall;
  logic f_validE, f_readyE, f_validM, f_regwriteM, f_resultsrcM, f_memwriteM;
  logic [DPW-1:0] f_aluresultM, f_Rd2M;
  logic [RAW-1:0] f_RdM;
  logic [CNTW-1:0] f_stall;

  logic readyE_v, validM_v, regwriteM_v, resultsrcM_v, memwriteM_v;
  logic [DPW-1:0] aluresultM_v, Rd2M_v;
  logic [RAW-1:0] RdM_v;
  logic [CNTW-1:0] stall_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign s_validE     = validE && use_skid;
  assign f_validE     = validE && !use_skid;
  assign readyE_v     = use_skid ? s_readyE     : f_readyE;
  assign validM_v     = use_skid ? s_validM     : f_validM;
  assign regwriteM_v  = use_skid ? s_regwriteM  : f_regwriteM;
  assign resultsrcM_v = use_skid ? s_resultsrcM : f_resultsrcM;
  assign memwriteM_v  = use_skid ? s_memwriteM  : f_memwriteM;
  assign aluresultM_v = use_skid ? s_aluresultM : f_aluresultM;
  assign Rd2M_v       = use_skid ? s_Rd2M       : f_Rd2M;
  assign RdM_v        = use_skid ? s_RdM        : f_RdM;
  assign stall_v      = use_skid ? s_stall      : f_stall;

  ex_mem_skid_reg #(.SKID(1'b1), .CNTW(CNTW)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .validE(s_validE), .readyE(s_readyE),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
    .aluresultE(aluresultE), .Rd2E(Rd2E), .RdE(RdE), .validM(s_validM), .readyM(readyM),
    .regwriteM(s_regwriteM), .resultsrcM(s_resultsrcM), .memwriteM(s_memwriteM),
    .aluresultM(s_aluresultM), .Rd2M(s_Rd2M), .RdM(s_RdM), .stall_cnt(s_stall)
  );

  ex_mem_skid_reg #(.SKID(1'b0), .CNTW(CNTW)) u_flat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .validE(f_validE), .readyE(f_readyE),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
    .aluresultE(aluresultE), .Rd2E(Rd2E), .RdE(RdE), .validM(f_validM), .readyM(readyM),
    .regwriteM(f_regwriteM), .resultsrcM(f_resultsrcM), .memwriteM(f_memwriteM),
    .aluresultM(f_aluresultM), .Rd2M(f_Rd2M), .RdM(f_RdM), .stall_cnt(f_stall)
  );

  task automatic drive(input logic rw, input logic rs, input logic mw,
                       input logic [DPW-1:0] alu, input logic [DPW-1:0] rd2, input logic [RAW-1:0] rd);
    regwriteE = rw; resultsrcE = rs; memwriteE = mw; aluresultE = alu; Rd2E = rd2; RdE = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL reset_validM: got %0b want 0", validM_v); end
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL reset_readyE: got %0b want 1", readyE_v); end
    n_cmp++; if (aluresultM_v !== '0) begin n_bad++; $display("FAIL reset_aluresultM: got %h want 0", aluresultM_v); end
    n_cmp++; if (stall_v !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_v); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    @(negedge clk);
    readyM = 1'b1; validE = 1'b1; drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk);
    validE = 1'b0;
    n_cmp++; if (validM_v !== 1'b1) begin n_bad++; $display("FAIL single_validM: got %0b want 1", validM_v); end
    n_cmp++; if (regwriteM_v !== 1'b1) begin n_bad++; $display("FAIL single_regwriteM: got %0b want 1", regwriteM_v); end
    n_cmp++; if (aluresultM_v !== 32'h0000_1234) begin n_bad++; $display("FAIL single_aluresultM: got %h want 00001234", aluresultM_v); end
    n_cmp++; if (RdM_v !== 5'd5) begin n_bad++; $display("FAIL single_RdM: got %0d want 5", RdM_v); end
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL single_readyE: got %0b want 1", readyE_v); end
    @(negedge clk);
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL single_drain_validM: got %0b want 0", validM_v); end
    n_cmp++; if (regwriteM_v !== 1'b0) begin n_bad++; $display("FAIL single_drain_regwriteM: got %0b want 0", regwriteM_v); end
  endtask

  task automatic test_backpressure();
    readyM = 1'b0; validE = 1'b1; drive(1'b1, 1'b0, 1'b0, 32'hA, 32'h0, 5'd1);
    @(negedge clk);
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL bp_readyE_one: got %0b want 1", readyE_v); end
    drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 5'd2);
    @(negedge clk);
    validE = 1'b0;
    n_cmp++; if (readyE_v !== 1'b0) begin n_bad++; $display("FAIL bp_readyE_full: got %0b want 0", readyE_v); end
    n_cmp++; if (aluresultM_v !== 32'hA) begin n_bad++; $display("FAIL bp_head_A: got %h want a", aluresultM_v); end
    @(negedge clk);
    n_cmp++; if (stall_v !== 4'd2) begin n_bad++; $display("FAIL bp_stall_cnt: got %0d want 2", stall_v); end
    readyM = 1'b1;
    #1;
    n_cmp++; if (aluresultM_v !== 32'hA || validM_v !== 1'b1) begin n_bad++; $display("FAIL bp_first_A: got %h/%0b want a/1", aluresultM_v, validM_v); end
    @(negedge clk);
    n_cmp++; if (aluresultM_v !== 32'hB || validM_v !== 1'b1) begin n_bad++; $display("FAIL bp_second_B: got %h/%0b want b/1", aluresultM_v, validM_v); end
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL bp_readyE_reopen: got %0b want 1", readyE_v); end
    @(negedge clk);
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %0b want 0", validM_v); end
  endtask

  task automatic test_flush();
    readyM = 1'b0; validE = 1'b1; drive(1'b1, 1'b0, 1'b1, 32'hC, 32'hC0, 5'd3);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'hD, 32'hD0, 5'd4);
    @(negedge clk);
    flush_i = 1'b1; drive(1'b1, 1'b0, 1'b1, 32'hE, 32'hE0, 5'd6);
    @(negedge clk);
    flush_i = 1'b0; validE = 1'b0;
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL flush_full_validM: got %0b want 0", validM_v); end
    n_cmp++; if (regwriteM_v !== 1'b0) begin n_bad++; $display("FAIL flush_full_regwriteM: got %0b want 0", regwriteM_v); end
    n_cmp++; if (memwriteM_v !== 1'b0) begin n_bad++; $display("FAIL flush_full_memwriteM: got %0b want 0", memwriteM_v); end
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL flush_full_readyE: got %0b want 1", readyE_v); end
    readyM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL flush_no_ghost[%0d]: got %0b want 0", i, validM_v); end
    end
    readyM = 1'b0; validE = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'hF, 32'h0, 5'd7);
    @(negedge clk);
    flush_i = 1'b1; drive(1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 5'd8);
    @(negedge clk);
    flush_i = 1'b0; validE = 1'b0; readyM = 1'b1;
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL flush_one_validM: got %0b want 0", validM_v); end
    @(negedge clk);
    n_cmp++; if (validM_v !== 1'b0) begin n_bad++; $display("FAIL flush_one_discard: got %0b want 0", validM_v); end
  endtask

  task automatic test_bubble();
    readyM = 1'b1; validE = 1'b1; drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 5'd3);
    @(negedge clk);
    validE = 1'b0; drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);
    n_cmp++; if (memwriteM_v !== 1'b1) begin n_bad++; $display("FAIL bubble_store_memwriteM: got %0b want 1", memwriteM_v); end
    n_cmp++; if (Rd2M_v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bubble_store_Rd2M: got %h want deadbeef", Rd2M_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (validM_v !== 1'b0 || memwriteM_v !== 1'b0) begin n_bad++; $display("FAIL bubble_squash[%0d]: got v=%0b mw=%0b want 0/0", i, validM_v, memwriteM_v); end
      n_cmp++; if (Rd2M_v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bubble_hold_Rd2M[%0d]: got %h want deadbeef", i, Rd2M_v); end
    end
  endtask

  task automatic test_flat_ready();
    use_skid = 1'b0; readyM = 1'b0; validE = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL flat_ready_empty: got %0b want 1", readyE_v); end
    validE = 1'b1; drive(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd9);
    @(negedge clk);
    validE = 1'b0; #1;
    n_cmp++; if (readyE_v !== 1'b0) begin n_bad++; $display("FAIL flat_ready_blocked: got %0b want 0", readyE_v); end
    readyM = 1'b1; #1;
    n_cmp++; if (readyE_v !== 1'b1) begin n_bad++; $display("FAIL flat_ready_passthru: got %0b want 1", readyE_v); end
    @(negedge clk);
    use_skid = 1'b1;
  endtask

  task automatic test_streaming(input bit skid);
    ex_mem_payload_t exp_q[$];
    ex_mem_payload_t tx, got, want;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    bit have = 1'b0;
    logic rdy_before;
    use_skid = skid; validE = 1'b0; readyM = 1'b0;
    tx = '0;
    while (rcvd < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      rdy_before = readyE_v;
      readyM = ($urandom_range(0, 2) != 0);
      if (!have && sent < 100 && $urandom_range(0, 3) != 0) begin
        tx.ctrl.regwrite = 1'($urandom_range(0, 1));
        tx.ctrl.resultsrc = 1'($urandom_range(0, 1));
        tx.ctrl.memwrite = 1'($urandom_range(0, 1));
        tx.aluresult = $urandom; tx.Rd2 = $urandom; tx.Rd = 5'($urandom_range(0, 31));
        drive(tx.ctrl.regwrite, tx.ctrl.resultsrc, tx.ctrl.memwrite, tx.aluresult, tx.Rd2, tx.Rd);
        validE = 1'b1; have = 1'b1;
      end else if (!have) begin
        validE = 1'b0;
      end
      #1;
      if (skid) begin
        n_cmp++; if (readyE_v !== rdy_before) begin n_bad++; $display("FAIL stream_readyE_comb: got %0b want %0b", readyE_v, rdy_before); end
      end
      if (validM_v && readyM) begin
        got = {regwriteM_v, resultsrcM_v, memwriteM_v, aluresultM_v, Rd2M_v, RdM_v};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra_beat: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_bad++; $display("FAIL stream_beat[%0d]: got %h want %h", rcvd, got, want); end
        end
        rcvd++;
      end
      if (validE && readyE_v) begin
        exp_q.push_back(tx); sent++; have = 1'b0;
      end
    end
    n_cmp++; if (rcvd != 100) begin n_bad++; $display("FAIL stream_count(skid=%0b): got %0d want 100", skid, rcvd); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL stream_leftover(skid=%0b): got %0d want 0", skid, exp_q.size()); end
    validE = 1'b0; readyM = 1'b1;
    repeat (3) @(negedge clk);
    use_skid = 1'b1;
  endtask

  task automatic test_stall_saturation();
    use_skid = 1'b1; readyM = 1'b0; validE = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    validE = 1'b1; drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h66, 5'd7);
    @(negedge clk);
    validE = 1'b0;
    n_cmp++; if (stall_v !== 4'd0) begin n_bad++; $display("FAIL stall_start: got %0d want 0", stall_v); end
    repeat (10) @(negedge clk);
    n_cmp++; if (stall_v !== 4'd10) begin n_bad++; $display("FAIL stall_ten: got %0d want 10", stall_v); end
    repeat (11) @(negedge clk);
    n_cmp++; if (stall_v !== 4'd15) begin n_bad++; $display("FAIL stall_saturate: got %0d want 15", stall_v); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (validM_v !== 1'b0 || regwriteM_v !== 1'b0 || resultsrcM_v !== 1'b0) begin n_bad++; $display("FAIL areset_ctrl: got v=%0b rw=%0b rs=%0b want 0", validM_v, regwriteM_v, resultsrcM_v); end
    n_cmp++; if (aluresultM_v !== '0 || Rd2M_v !== '0 || RdM_v !== '0) begin n_bad++; $display("FAIL areset_data: got %h %h %0d want 0", aluresultM_v, Rd2M_v, RdM_v); end
    n_cmp++; if (stall_v !== '0 || readyE_v !== 1'b1) begin n_bad++; $display("FAIL areset_cnt_ready: got %0d/%0b want 0/1", stall_v, readyE_v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; validE = 1'b0; readyM = 1'b0; use_skid = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    test_reset();
    test_single_beat();
    test_backpressure();
    test_flush();
    test_bubble();
    test_flat_ready();
    test_streaming(1'b1);
    test_streaming(1'b0);
    test_stall_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
